// File: rtl/sram_sp_arbiter.sv
// Two-port round-robin arbiter with lock in front of a single-port SRAM; routes read data back by id.
// Optional SRAM_ARB_STATS_EN adds saturating conflict and per-port grant counters.
module sram_sp_arbiter #(
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned DataWidth = 9,
    parameter int unsigned Latency   = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [1:0]                req_i,
    input  logic [1:0]                we_i,
    input  logic [1:0]                lock_i,
    input  logic [1:0][AddrWidth-1:0] addr_i,
    input  logic [1:0][DataWidth-1:0] wdata_i,
    output logic [1:0]                gnt_o,
    output logic [1:0]                rvalid_o,
    output logic [DataWidth-1:0]      rdata_o,
    output logic                      sram_wen_o,
    output logic [AddrWidth-1:0]      sram_addr_o,
    output logic [DataWidth-1:0]      sram_wdata_o,
    input  logic [DataWidth-1:0]      sram_rdata_i
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [15:0]               conflict_cnt_o,
    output logic [1:0][15:0]          grant_cnt_o
`endif
);

    if (Latency != 1 && Latency != 2) begin : gen_bad_latency
        $error("sram_sp_arbiter: Latency must be 1 or 2");
    end

    localparam logic OutStage = (Latency == 2);

    logic       rr_q, rr_d;
    logic       lock_vld_q, lock_vld_d;
    logic       lock_id_q, lock_id_d;
    logic [1:0] rd_vld_q, rd_vld_d;
    logic [1:0] rd_id_q, rd_id_d;
    logic       gnt_any, gnt_id, lock_cont;
    logic       unused_stage;

    always_comb begin
        lock_cont = lock_vld_q & req_i[lock_id_q] & lock_i[lock_id_q];
        gnt_any   = 1'b0;
        gnt_id    = 1'b0;
        if (!rst_i) begin
            if (lock_cont) begin
                gnt_any = 1'b1;
                gnt_id  = lock_id_q;
            end else if (req_i == 2'b11) begin
                gnt_any = 1'b1;
                gnt_id  = rr_q;
            end else if (req_i[0]) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b0;
            end else if (req_i[1]) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b1;
            end
        end

        gnt_o        = gnt_any ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
        sram_wen_o   = gnt_any & we_i[gnt_id];
        sram_addr_o  = gnt_any ? addr_i[gnt_id] : '0;
        sram_wdata_o = gnt_any ? wdata_i[gnt_id] : '0;

        // Locked continuations leave the round-robin pointer untouched.
        rr_d = rr_q;
        if (gnt_any && !lock_cont) begin
            rr_d = ~gnt_id;
        end
        lock_vld_d = gnt_any & lock_i[gnt_id];
        lock_id_d  = gnt_id;

        rd_vld_d = {rd_vld_q[0], gnt_any & ~we_i[gnt_id]};
        rd_id_d  = {rd_id_q[0], gnt_id};

        rvalid_o = 2'b00;
        if (!rst_i && rd_vld_q[OutStage]) begin
            rvalid_o = rd_id_q[OutStage] ? 2'b10 : 2'b01;
        end
        rdata_o = sram_rdata_i;
    end

    // Stage 1 is only observed when Latency is 2.
    assign unused_stage = ^{rd_vld_q, rd_id_q};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= 1'b0;
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
            rd_vld_q   <= 2'b00;
            rd_id_q    <= 2'b00;
        end else begin
            rr_q       <= rr_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            rd_vld_q   <= rd_vld_d;
            rd_id_q    <= rd_id_d;
        end
    end

`ifdef SRAM_ARB_STATS_EN
    logic [15:0]      conflict_q;
    logic [1:0][15:0] grant_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conflict_q <= '0;
            grant_q    <= '0;
        end else begin
            if (req_i == 2'b11 && conflict_q != 16'hFFFF) begin
                conflict_q <= conflict_q + 16'd1;
            end
            for (int p = 0; p < 2; p++) begin
                if (req_i[p] && gnt_o[p] && grant_q[p] != 16'hFFFF) begin
                    grant_q[p] <= grant_q[p] + 16'd1;
                end
            end
        end
    end

    assign conflict_cnt_o = conflict_q;
    assign grant_cnt_o    = grant_q;
`endif

endmodule

// File: doc/sram_sp_arbiter.md
Name: sram_sp_arbiter

Overview:
- Two-requester arbiter in front of a single-port SRAM macro (sram_sp wrapper) in the FFT pipeline.
- Typical requesters: port 0 is the sample loader/writer, port 1 is the butterfly stage reader/writer.
- Grants at most one access per cycle using round-robin with optional lock.
- Tracks in-flight reads through the SRAM latency and routes read data back to the issuing port.

Parameters:
AddrWidth, 10, SRAM word-address width.
DataWidth, 9, SRAM word width.
Latency, 1, SRAM read latency in cycles. Legal values are 1 or 2; any other value is an elaboration error.

Ports:
clk_i  input  1  clock, all logic on the rising edge
rst_i  input  1  synchronous reset, active-high
req_i  input  2  per-port access request
we_i  input  2  per-port write enable (1 = write, 0 = read)
lock_i  input  2  per-port lock; holds the grant while req and lock stay high
addr_i  input  2xAddrWidth  per-port word address
wdata_i  input  2xDataWidth  per-port write data
gnt_o  output  2  one-hot grant (combinational); transfer = req_i[p] & gnt_o[p]
rvalid_o  output  2  per-port read-data valid (registered), one-hot or zero
rdata_o  output  DataWidth  read data, qualified by rvalid_o
sram_wen_o  output  1  to SRAM wen_i
sram_addr_o  output  AddrWidth  to SRAM addr
sram_wdata_o  output  DataWidth  to SRAM wdata_i
sram_rdata_i  input  DataWidth  from SRAM rdata_o

Behaviour:
- Reset (rst_i high at a clock edge): rr_q = 0 (port 0 has priority), lock_owner_q = none, rvalid pipeline cleared, rvalid_o = 0.
- While rst_i is high: gnt_o = 0, sram_wen_o = 0, sram_addr_o = 0, sram_wdata_o = 0.
- Arbitration, evaluated combinationally each cycle:
  - If lock_owner_q = p and req_i[p] = 1, grant p.
  - Otherwise, if only one port requests, grant it.
  - If both request, grant rr_q.
  - If neither requests, gnt_o = 0.
- Round-robin update: on any grant to port p that is not a locked continuation, rr_q <= ~p.
- Lock:
  - A grant to p with lock_i[p] = 1 sets lock_owner_q = p.
  - lock_owner_q clears on the first cycle that lock_owner_q = p and req_i[p] = 0 or lock_i[p] = 0. The arbitration in that cycle is normal round-robin.
  - A locked burst does not update rr_q.
- SRAM drive when a port g is granted: sram_wen_o = we_i[g], sram_addr_o = addr_i[g], sram_wdata_o = wdata_i[g].
- SRAM drive when idle: sram_wen_o = 0; address and wdata are 0.
- Reads: a granted read (we_i[g] = 0) issued in cycle N gives rvalid_o[g] = 1 in cycle N+Latency, with rdata_o = sram_rdata_i.
  - A 2-entry valid/id shift pipeline tracks reads. Only the first Latency stages are used.
  - One read is accepted per cycle with no stalls, giving full throughput.
- Writes produce no response and complete in the grant cycle.
- Simultaneous events:
  - Both ports request in the same cycle: exactly one grant.
  - The losing port keeps req asserted and must hold its addr/wdata/we stable.
- Reset mid-operation: in-flight reads are discarded; rvalid_o = 0 on the cycle after reset, with no late responses.
- Latency = 2: back-to-back reads from alternating ports return in issue order, with the id tags preserved.

Optional Feature:
- Macro: SRAM_ARB_STATS_EN.
- Enabled: adds output ports conflict_cnt_o (16 bits) and grant_cnt_o (2x16 bits).
  - conflict_cnt_o increments on each cycle where req_i = 2'b11.
  - grant_cnt_o[p] increments on each transfer by port p.
  - All counters saturate at 16'hFFFF and reset to 0 on rst_i.
- Disabled: these ports and registers do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset, Latency = 1: rst_i high for 2 cycles, then port 0 writes addr 5 = 9'h1A5 -> gnt_o = 01, sram_wen_o = 1, sram_addr_o = 5. Next cycle port 1 reads addr 5 -> rvalid_o = 10 one cycle later, rdata_o = 9'h1A5.
- Contention: both ports hold req_i = 11 (reads, no lock) for 4 cycles -> grants 01, 10, 01, 10 -> rvalid_o follows one cycle behind in the same order.
- Lock: port 1 asserts req + lock for 3 cycles while port 0 also requests -> gnt_o = 10 for all 3 cycles. Port 1 then drops lock -> port 0 is granted the next cycle.
- Latency = 2: alternating reads to addrs 1 (port 0) and 2 (port 1) on consecutive cycles -> responses 2 cycles after each issue, with correct id and data.
- Reset mid-read: issue a read, assert rst_i in the next cycle -> rvalid_o stays 0 and no response appears afterwards.
- SRAM_ARB_STATS_EN: 10 contention cycles -> conflict_cnt_o = 10 and grant_cnt_o = {5, 5}. Preloading the counter to 16'hFFFE via 2+ further conflicts holds 16'hFFFF.
